// File: rtl/uart_tx_queue.sv
// Purpose : transmit byte FIFO feeding the simpleuart data write port (reg_dat_we/di/wait).
// Latency : a byte pushed into an empty queue at edge N is presented to the UART in cycle N+1.
// Backpr. : in_ready drops when full, in reset or in a flush cycle; uart_dat_wait holds the head byte.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   in_valid/in_data    - producer byte stream; in_ready = room available this cycle
//   flush               - synchronous discard of every queued byte (beats push and pop)
//   uart_dat_we/di      - UART write strobe (bit 0 only) and {24'h0, byte}
//   uart_dat_wait       - UART stall; high means the presented byte was not taken
//   level/empty/full    - number of stored bytes and its boundary flags
//
// Build option: define UART_TXQ_CRLF_EN to expand each stored 8'h0A into 8'h0D, 8'h0A
// on the UART side. Without it every byte is sent verbatim.

module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [3:0]            uart_dat_we,
    output logic [31:0]           uart_dat_di,
    input  logic                  uart_dat_wait,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] FULL_XOR = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    logic          w_empty;
    logic          w_full;
    logic          w_in_ready;
    logic          w_push;
    logic          w_present;
    logic          w_accept;
    logic          w_pop;
    logic [7:0]    w_head;
    logic [7:0]    w_out_byte;
    logic [PW-1:0] w_level;

    // ------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = ((r_wr_ptr ^ r_rd_ptr) == FULL_XOR);
    // Modular difference of the wrap-extended pointers is exactly 0..DEPTH.
    assign w_level = r_wr_ptr - r_rd_ptr;

    assign level = w_level;
    assign empty = w_empty;
    assign full  = w_full;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    // A pop in the same cycle does not open a slot when full: in_ready is
    // derived from registered occupancy only, keeping it off the UART path.
    assign w_in_ready = !w_full && !reset && !flush;
    assign in_ready   = w_in_ready;
    assign w_push     = in_valid && w_in_ready;

    // Storage needs no reset; only entries between the pointers are ever read out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    assign w_head = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    // The strobe depends only on registered state and flush, never on
    // uart_dat_wait, so the UART sees a stable request while it stalls.
    assign w_present = !w_empty && !flush;
    assign w_accept  = w_present && !uart_dat_wait;

`ifdef UART_TXQ_CRLF_EN
    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_LF_PEND = 1'b1
    } crlf_state_t;

    crlf_state_t r_state;
    logic        w_insert_cr;

    // In NORMAL a head LF is first sent as CR; the LF itself stays queued
    // until the LF_PEND pass, so level never counts the inserted CR.
    assign w_insert_cr = (r_state == ST_NORMAL) && (w_head == 8'h0A);
    assign w_out_byte  = w_insert_cr ? 8'h0D : w_head;
    assign w_pop       = w_accept && !w_insert_cr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state <= ST_NORMAL;
        end else if (w_accept) begin
            case (r_state)
                ST_NORMAL: begin
                    if (w_head == 8'h0A) begin
                        r_state <= ST_LF_PEND;
                    end
                end
                ST_LF_PEND: begin
                    r_state <= ST_NORMAL;
                end
                default: begin
                    r_state <= ST_NORMAL;
                end
            endcase
        end
    end
`else
    assign w_out_byte = w_head;
    assign w_pop      = w_accept;
`endif

    assign uart_dat_we = {3'b000, w_present};
    assign uart_dat_di = w_present ? {24'h0, w_out_byte} : 32'h0;

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            // Collapse the queue without touching the write pointer.
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule
